// File: rtl/exe_pkg.sv
// Shared definitions for the execute unit.
// Contents: EXE_CMD opcode encodings, register shift-type encodings,
// the execute FSM state type and the bit positions of the {N,Z,C,V} status.
package exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam int unsigned N_BIT = 3;
    localparam int unsigned Z_BIT = 2;
    localparam int unsigned C_BIT = 1;
    localparam int unsigned V_BIT = 0;

endpackage

// File: rtl/val2_gen.sv
// Second-operand (Val2) generator.
// Ports:
//   mem           - load/store: Val2 is the zero-extended 12-bit offset
//   imm           - immediate: 8-bit constant rotated right by 2*rot field
//   shift_operand - 12-bit operand/shift field
//   val_rm        - register operand shifted when neither mem nor imm
//   val2          - resulting WIDTH-bit second operand
module val2_gen
    import exe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             mem,
    input  logic             imm,
    input  logic [11:0]      shift_operand,
    input  logic [WIDTH-1:0] val_rm,
    output logic [WIDTH-1:0] val2
);

    // Rotate right within WIDTH bits; amounts of WIDTH or more wrap around.
    function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] x,
                                             input int unsigned amt);
        logic [2*WIDTH-1:0] d;
        d = {x, x} >> (amt % WIDTH);
        return d[WIDTH-1:0];
    endfunction

    always_comb begin
        val2 = '0;
        if (mem) begin
            val2 = {{(WIDTH-12){1'b0}}, shift_operand};
        end else if (imm) begin
            val2 = ror({{(WIDTH-8){1'b0}}, shift_operand[7:0]},
                       {27'd0, shift_operand[11:8], 1'b0});
        end else begin
            case (shift_t'(shift_operand[6:5]))
                SH_LSL:  val2 = val_rm << shift_operand[11:7];
                SH_LSR:  val2 = val_rm >> shift_operand[11:7];
                SH_ASR:  val2 = $signed(val_rm) >>> shift_operand[11:7];
                SH_ROR:  val2 = ror(val_rm, {27'd0, shift_operand[11:7]});
                default: val2 = val_rm;
            endcase
        end
    end

endmodule

// File: rtl/exe_unit_pipe.sv
// Pipelined execute unit: single-cycle ALU with a registered, back-pressured
// output stage plus an iterative shift-add multiplier (WIDTH cycles).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid / in_ready      - operation handshake
//   flush                    - drop held/in-flight results, abort MUL
//   EXE_CMD, MEM_R_EN/W_EN   - opcode and load/store select
//   PC, Val_Rn, Val_Rm, imm, Shift_operand, signed_imm_24, SR {N,Z,C,V}
//   out_valid / out_ready    - result handshake
//   ALU_result, Br_addr, status {N,Z,C,V} - registered results
module exe_unit_pipe
    import exe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [3:0]       EXE_CMD,
    input  logic             MEM_R_EN,
    input  logic             MEM_W_EN,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] Val_Rn,
    input  logic [WIDTH-1:0] Val_Rm,
    input  logic             imm,
    input  logic [11:0]      Shift_operand,
    input  logic [23:0]      signed_imm_24,
    input  logic [3:0]       SR,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic [WIDTH-1:0] Br_addr,
    output logic [3:0]       status
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    mul_cnt;
    logic [WIDTH-1:0] mul_acc, mul_mcand, mul_mplier, mul_br, mul_step;
    logic [1:0]       mul_cv;

    logic [WIDTH-1:0] val2, add_b, alu_res, br_off, br_next;
    logic [WIDTH:0]   sum;
    logic [3:0]       alu_st;
    logic             add_cin, is_nop, is_mul, accept;
    logic signed [25:0] off26;

    val2_gen #(.WIDTH(WIDTH)) u_val2 (
        .mem           (MEM_R_EN | MEM_W_EN),
        .imm           (imm),
        .shift_operand (Shift_operand),
        .val_rm        (Val_Rm),
        .val2          (val2)
    );

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign is_mul   = (MUL_EN != 0) && (EXE_CMD == CMD_MUL);

    assign off26    = {signed_imm_24, 2'b00};
    assign br_off   = WIDTH'(off26);
    assign br_next  = PC + br_off;

    assign mul_step = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

    // Subtraction is Rn + ~Val2 + cin, so the carry-out is the no-borrow flag.
    always_comb begin
        add_b   = ((EXE_CMD == CMD_SUB) || (EXE_CMD == CMD_SBC)) ? ~val2 : val2;
        add_cin = 1'b0;
        case (EXE_CMD)
            CMD_SUB:          add_cin = 1'b1;
            CMD_ADC, CMD_SBC: add_cin = SR[C_BIT];
            default:          add_cin = 1'b0;
        endcase
        sum = {1'b0, Val_Rn} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    end

    // MUL falls into the NOP arm here: it either runs on the iterative path
    // or, with MUL_EN=0, really is a NOP.
    always_comb begin
        alu_res = '0;
        alu_st  = SR;
        is_nop  = 1'b0;
        case (EXE_CMD)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                alu_res       = sum[WIDTH-1:0];
                alu_st[C_BIT] = sum[WIDTH];
                alu_st[V_BIT] = (Val_Rn[WIDTH-1] == add_b[WIDTH-1]) &&
                                (sum[WIDTH-1] != Val_Rn[WIDTH-1]);
            end
            CMD_AND: alu_res = Val_Rn & val2;
            CMD_ORR: alu_res = Val_Rn | val2;
            CMD_EOR: alu_res = Val_Rn ^ val2;
            default: is_nop  = 1'b1;
        endcase
        if (!is_nop) begin
            alu_st[N_BIT] = alu_res[WIDTH-1];
            alu_st[Z_BIT] = (alu_res == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            ALU_result <= '0;
            Br_addr    <= '0;
            status     <= '0;
            mul_cnt    <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_br     <= '0;
            mul_cv     <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_mul) begin
                        // Output slot is free (or drained this edge) at MUL accept.
                        state      <= MUL;
                        out_valid  <= 1'b0;
                        mul_cnt    <= '0;
                        mul_acc    <= '0;
                        mul_mcand  <= Val_Rn;
                        mul_mplier <= Val_Rm;
                        mul_br     <= br_next;
                        mul_cv     <= SR[1:0];
                    end else if (accept) begin
                        ALU_result <= alu_res;
                        Br_addr    <= br_next;
                        status     <= alu_st;
                        out_valid  <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    mul_acc    <= mul_step;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    mul_cnt    <= mul_cnt + CW'(1);
                    if (mul_cnt == CW'(WIDTH - 1)) begin
                        state      <= IDLE;
                        out_valid  <= 1'b1;
                        ALU_result <= mul_step;
                        Br_addr    <= mul_br;
                        status     <= {mul_step[WIDTH-1], mul_step == '0, mul_cv};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_unit_pipe.sv
module tb_exe_unit_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [3:0]  EXE_CMD, SR, status;
    logic        MEM_R_EN, MEM_W_EN, imm;
    logic [31:0] PC, Val_Rn, Val_Rm, ALU_result, Br_addr;
    logic [11:0] Shift_operand;
    logic [23:0] signed_imm_24;

    int tests_run    = 0;
    int tests_failed = 0;

    exe_unit_pipe #(.WIDTH(32), .MUL_EN(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flush         (flush),
        .EXE_CMD       (EXE_CMD),
        .MEM_R_EN      (MEM_R_EN),
        .MEM_W_EN      (MEM_W_EN),
        .PC            (PC),
        .Val_Rn        (Val_Rn),
        .Val_Rm        (Val_Rm),
        .imm           (imm),
        .Shift_operand (Shift_operand),
        .signed_imm_24 (signed_imm_24),
        .SR            (SR),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ALU_result    (ALU_result),
        .Br_addr       (Br_addr),
        .status        (status)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_val2(input logic mr, input logic mw, input logic immf,
                                           input logic [11:0] so, input logic [31:0] rm);
        logic [63:0] d;
        int unsigned n;
        if (mr || mw) return {20'd0, so};
        if (immf) begin
            n = 2 * so[11:8];
            d = {56'd0, so[7:0]};
            return 32'((d >> n) | (d << (32 - n)));
        end
        n = so[11:7];
        case (so[6:5])
            2'd0:    return rm << n;
            2'd1:    return rm >> n;
            2'd2:    return (rm >> n) | (rm[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0);
            default: begin d = {rm, rm}; return 32'(d >> n); end
        endcase
    endfunction

    function automatic void model(input logic [3:0] cmd, input logic mr, input logic mw,
                                  input logic [31:0] pc, input logic [31:0] rn, input logic [31:0] rm,
                                  input logic immf, input logic [11:0] so, input logic [23:0] i24,
                                  input logic [3:0] sr,
                                  output logic [31:0] res, output logic [31:0] br, output logic [3:0] st);
        logic [31:0] v2;
        longint sa, sb, s;
        longint unsigned ua, ub, u, ci;
        logic nf, zf, cf, vf, nop;
        v2 = m_val2(mr, mw, immf, so, rm);
        sa = longint'($signed(rn));
        sb = longint'($signed(v2));
        ua = longint'(rn);
        ub = longint'(v2);
        {nf, zf, cf, vf} = sr;
        nop = 1'b0;
        res = 32'd0;
        case (cmd)
            4'd1: res = v2;
            4'd9: res = ~v2;
            4'd2, 4'd3: begin
                ci  = (cmd == 4'd3) ? longint'(sr[1]) : 0;
                u   = ua + ub + ci;
                res = 32'(u);
                cf  = (u >= 64'h1_0000_0000);
                s   = sa + sb + longint'(ci);
                vf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4, 4'd5: begin
                ci  = (cmd == 4'd5) ? longint'(!sr[1]) : 0;
                res = 32'(ua - ub - ci);
                cf  = (ua >= ub + ci);
                s   = sa - sb - longint'(ci);
                vf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6: res = rn & v2;
            4'd7: res = rn | v2;
            4'd8: res = rn ^ v2;
            4'd10: res = 32'(ua * longint'(rm));
            default: nop = 1'b1;
        endcase
        if (!nop) begin
            nf = res[31];
            zf = (res == 32'd0);
        end
        st = {nf, zf, cf, vf};
        br = pc + 32'(longint'($signed(i24)) * 4);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] cmd, input logic mr, input logic mw,
                         input logic [31:0] pc, input logic [31:0] rn, input logic [31:0] rm,
                         input logic immf, input logic [11:0] so, input logic [23:0] i24,
                         input logic [3:0] sr);
        EXE_CMD = cmd; MEM_R_EN = mr; MEM_W_EN = mw; PC = pc; Val_Rn = rn; Val_Rm = rm;
        imm = immf; Shift_operand = so; signed_imm_24 = i24; SR = sr;
        in_valid = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        issue(4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        repeat (3) step;
        rst = 1'b0;
        tests_run++;
        if ({out_valid, ALU_result, Br_addr, status} !== 69'd0) begin
            tests_failed++;
            $display("FAIL reset_state got ov=%b res=%h br=%h st=%b exp all zero",
                     out_valid, ALU_result, Br_addr, status);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_add_overflow;
        logic [31:0] er, eb; logic [3:0] es;
        out_ready = 1'b1;
        issue(4'b0010, 0, 0, 32'h1234, 32'h7FFF_FFFF, 32'hDEAD, 1, 12'h001, 24'h000010, 4'b0000);
        model(EXE_CMD, MEM_R_EN, MEM_W_EN, PC, Val_Rn, Val_Rm, imm, Shift_operand, signed_imm_24, SR, er, eb, es);
        step;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || ALU_result !== 32'h8000_0000 || status !== 4'b1001 || Br_addr !== eb) begin
            tests_failed++;
            $display("FAIL add_overflow got ov=%b res=%h st=%b br=%h exp 1 80000000 1001 %h",
                     out_valid, ALU_result, status, Br_addr, eb);
        end
        step;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_drain got ov=%b exp 0", out_valid);
        end
    endtask

    task automatic test_sub_zero;
        issue(4'b0100, 0, 0, 0, 32'd5, 32'd5, 0, 12'h000, 0, 4'b1001);
        step;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || ALU_result !== 32'd0 || status !== 4'b0110) begin
            tests_failed++;
            $display("FAIL sub_zero got ov=%b res=%h st=%b exp 1 00000000 0110",
                     out_valid, ALU_result, status);
        end
        step;
    endtask

    task automatic test_imm_mov;
        issue(4'b0001, 0, 0, 0, 32'h5555, 32'hAAAA, 1, 12'h4FF, 0, 4'b0010);
        step;
        issue(4'b1001, 0, 0, 0, 32'h5555, 32'hAAAA, 1, 12'h4FF, 0, 4'b0001);
        tests_run++;
        if (out_valid !== 1'b1 || ALU_result !== 32'hFF00_0000 || status !== 4'b1010) begin
            tests_failed++;
            $display("FAIL imm_mov got ov=%b res=%h st=%b exp 1 ff000000 1010",
                     out_valid, ALU_result, status);
        end
        step;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || ALU_result !== 32'h00FF_FFFF || status !== 4'b0001) begin
            tests_failed++;
            $display("FAIL imm_mvn got ov=%b res=%h st=%b exp 1 00ffffff 0001",
                     out_valid, ALU_result, status);
        end
        step;
    endtask

    task automatic run_mul(input string name, input logic [31:0] rn, input logic [31:0] rm,
                           input logic [3:0] sr);
        logic [31:0] er, eb; logic [3:0] es;
        int low_cycles;
        out_ready = 1'b1;
        issue(4'b1010, 0, 0, $urandom, rn, rm, 0, 12'($urandom), 24'($urandom), sr);
        model(EXE_CMD, MEM_R_EN, MEM_W_EN, PC, Val_Rn, Val_Rm, imm, Shift_operand, signed_imm_24, SR, er, eb, es);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_accept_ready got %b exp 1", name, in_ready);
        end
        step;
        in_valid = 1'b0;
        low_cycles = 0;
        for (int i = 0; i < 32; i++) begin
            if (in_ready === 1'b0 && out_valid === 1'b0) low_cycles++;
            step;
        end
        tests_run++;
        if (low_cycles != 32) begin
            tests_failed++;
            $display("FAIL %s_busy_cycles got %0d exp 32", name, low_cycles);
        end
        tests_run++;
        if (out_valid !== 1'b1 || ALU_result !== er || status !== es || Br_addr !== eb || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_result got ov=%b res=%h st=%b br=%h rdy=%b exp 1 %h %b %h 1",
                     name, out_valid, ALU_result, status, Br_addr, in_ready, er, es, eb);
        end
        step;
    endtask

    task automatic test_mul;
        run_mul("mul_dir", 32'h0001_0000, 32'h0001_0001, 4'b0011);
        tests_run++;
        if (ALU_result !== 32'h0001_0000) begin
            tests_failed++;
            $display("FAIL mul_dir_const got %h exp 00010000", ALU_result);
        end
        for (int k = 0; k < 3; k++)
            run_mul("mul_rand", $urandom, $urandom, 4'($urandom));
    endtask

    task automatic test_flush;
        int seen;
        out_ready = 1'b1;
        issue(4'b1010, 0, 0, 0, 32'd7, 32'd9, 0, 0, 0, 0);
        step;
        in_valid = 1'b0;
        repeat (9) step;
        flush = 1'b1;
        step;
        flush = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_mul_ready got %b exp 1", in_ready);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0) seen++;
            step;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL flush_mul_no_result got %0d valid cycles exp 0", seen);
        end
        // held result discarded, and an op presented with flush is dropped
        out_ready = 1'b0;
        issue(4'b0010, 0, 0, 0, 32'd1, 32'd2, 0, 0, 0, 0);
        step;
        flush = 1'b1;
        step;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_held got ov=%b exp 0", out_valid);
        end
        step;
        flush = 1'b0;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_drop_op got ov=%b exp 0", out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] r1, b1, r2, b2; logic [3:0] s1, s2;
        out_ready = 1'b0;
        issue(4'b0010, 0, 0, 32'h4000, 32'h1111_0000, 32'h0000_2222, 0, 12'h000, 24'h000003, 4'b0000);
        model(EXE_CMD, MEM_R_EN, MEM_W_EN, PC, Val_Rn, Val_Rm, imm, Shift_operand, signed_imm_24, SR, r1, b1, s1);
        step;
        issue(4'b0010, 0, 0, 32'h0000_0100, 32'hFFFF_FFFF, 32'd3, 0, 12'h080, 24'hFFFFFF, 4'b0000);
        model(EXE_CMD, MEM_R_EN, MEM_W_EN, PC, Val_Rn, Val_Rm, imm, Shift_operand, signed_imm_24, SR, r2, b2, s2);
        step;
        step;
        tests_run++;
        if (out_valid !== 1'b1 || ALU_result !== r1 || Br_addr !== b1 || status !== s1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_hold got ov=%b res=%h br=%h st=%b rdy=%b exp 1 %h %h %b 0",
                     out_valid, ALU_result, Br_addr, status, in_ready, r1, b1, s1);
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_release_ready got %b exp 1", in_ready);
        end
        step;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || ALU_result !== r2 || status !== s2 || Br_addr !== 32'h0000_00FC) begin
            tests_failed++;
            $display("FAIL b2b_second got ov=%b res=%h st=%b br=%h exp 1 %h %b 000000fc",
                     out_valid, ALU_result, status, Br_addr, r2, s2);
        end
        step;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drain got ov=%b exp 0", out_valid);
        end
    endtask

    task automatic test_random;
        logic        mov, exp_rdy;
        logic [31:0] hr, hb, tr, tb;
        logic [3:0]  hs, ts, cmd;
        mov = 1'b0; hr = 0; hb = 0; hs = 0;
        for (int i = 0; i < 300; i++) begin
            cmd = 4'($urandom_range(0, 15));
            if (cmd == 4'd10) cmd = 4'd3;
            issue(cmd, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), $urandom, $urandom,
                  $urandom, 1'($urandom), 12'($urandom), 24'($urandom), 4'($urandom));
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = !mov || out_ready;
            tests_run++;
            if (in_ready !== exp_rdy || out_valid !== mov ||
                (mov && (ALU_result !== hr || Br_addr !== hb || status !== hs))) begin
                tests_failed++;
                $display("FAIL random[%0d] got rdy=%b ov=%b res=%h br=%h st=%b exp %b %b %h %h %b",
                         i, in_ready, out_valid, ALU_result, Br_addr, status, exp_rdy, mov, hr, hb, hs);
            end
            model(EXE_CMD, MEM_R_EN, MEM_W_EN, PC, Val_Rn, Val_Rm, imm, Shift_operand, signed_imm_24, SR, tr, tb, ts);
            step;
            if (in_valid && exp_rdy) begin
                mov = 1'b1; hr = tr; hb = tb; hs = ts;
            end else if (out_ready) begin
                mov = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step;
    endtask

    task automatic test_reset_abort;
        int seen;
        out_ready = 1'b0;
        issue(4'b0111, 0, 0, 32'h8000, 32'hF0F0_0000, 32'h0F0F, 0, 0, 24'h000100, 4'b1111);
        step;
        in_valid = 1'b0;
        rst = 1'b1;
        step;
        rst = 1'b0;
        tests_run++;
        if ({out_valid, ALU_result, Br_addr, status} !== 69'd0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_clears got ov=%b res=%h br=%h st=%b rdy=%b exp zeros rdy=1",
                     out_valid, ALU_result, Br_addr, status, in_ready);
        end
        out_ready = 1'b1;
        issue(4'b1010, 0, 0, 0, 32'd3, 32'd4, 0, 0, 0, 0);
        step;
        in_valid = 1'b0;
        repeat (5) step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_abort_ready got %b exp 1", in_ready);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0) seen++;
            step;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL reset_abort_no_result got %0d valid cycles exp 0", seen);
        end
    endtask

    initial begin
        test_reset;
        test_add_overflow;
        test_sub_zero;
        test_imm_mov;
        test_mul;
        test_flush;
        test_back_to_back;
        test_random;
        test_reset_abort;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/exe_unit_pipe.md
EXE_UNIT_PIPE -- requirements
Module: exe_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values are multiples of 8 and at least 16.
REQ-002 SHALL have parameter MUL_EN, default 1; 1 enables the iterative MUL command, 0 treats MUL as NOP.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, an operation is presented.
REQ-006 SHALL have port in_ready, output, 1, the unit accepts an operation this cycle.
REQ-007 SHALL have port flush, input, 1, discard in-flight and pending results.
REQ-008 SHALL have port EXE_CMD, input, 4, operation code.
REQ-009 SHALL have ports MEM_R_EN and MEM_W_EN, input, 1 each, load/store select.
REQ-010 SHALL have ports PC, Val_Rn and Val_Rm, input, WIDTH each; imm, input, 1; Shift_operand, input, 12; signed_imm_24, input, 24; SR, input, 4, ordered {N,Z,C,V}.
REQ-011 SHALL have port out_valid, output, 1, a result is held; out_ready, input, 1, the consumer takes it.
REQ-012 SHALL have ports ALU_result and Br_addr, output, WIDTH each; status, output, 4, ordered {N,Z,C,V}.

Function
REQ-013 SHALL accept an operation when in_valid && in_ready && !flush.
REQ-014 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-015 SHALL, for single-cycle commands, register the result so out_valid rises on the cycle after accept.
REQ-016 SHALL hold ALU_result, Br_addr and status stable while out_valid && !out_ready, and clear out_valid on out_ready when no new result is loaded.
REQ-017 SHALL form Val2 as follows:
- MEM_R_EN|MEM_W_EN: zero-extended Shift_operand.
- imm=1: Shift_operand[7:0] zero-extended, then rotated right by 2*Shift_operand[11:8].
- Otherwise: Val_Rm shifted by Shift_operand[11:7] with type Shift_operand[6:5] (LSL, LSR, ASR, ROR).
REQ-018 SHALL decode EXE_CMD as follows:
- 0001 MOV = Val2; 1001 MVN = ~Val2.
- 0010 ADD; 0011 ADC (+C); 0100 SUB; 0101 SBC (Val_Rn-Val2-!C).
- 0110 AND; 0111 ORR; 1000 EOR.
- 1010 MUL = low WIDTH bits of Val_Rn*Val_Rm.
- Any other code: NOP, result 0, status = SR.
REQ-019 SHALL set N = result MSB and Z = (result==0) for every non-NOP command.
REQ-020 SHALL set C and V for add/sub commands as ARM does, with C = no-borrow for SUB/SBC; other commands pass C and V through from SR.
REQ-021 SHALL compute Br_addr = PC + (sign-extended signed_imm_24 << 2), truncated to WIDTH, wrapping without flags.
REQ-022 SHALL use an FSM with states IDLE and MUL.
- IDLE: on accepting MUL, latch the operands and go to MUL.
- MUL: perform one shift-add step per cycle for exactly WIDTH cycles, then load the output register and return to IDLE.
- MUL accept to out_valid latency is WIDTH+1 cycles.
REQ-023 SHALL keep in_ready low for the whole time the FSM is in MUL.
REQ-024 SHALL, on flush, clear out_valid, abort any MUL, and return to IDLE on the next edge; an operation presented in the same cycle is dropped.
REQ-025 SHALL, when out_ready and a new accept coincide, load the new result with out_valid remaining 1 and no bubble.
REQ-026 SHALL treat overflow of the MUL high bits as discarded, with C and V passed through from SR.

Reset
REQ-027 SHALL, when rst is high at a clock edge, set state=IDLE, out_valid=0, ALU_result=0, Br_addr=0 and status=0, aborting any operation in progress.
REQ-028 SHALL drive in_ready=1 in the first cycle after rst is released.

Structure
REQ-029 SHALL place the EXE_CMD encodings, shift-type encodings, FSM state type and status bit indices in shared package exe_pkg.
REQ-030 SHALL implement Val2 formation in one sub-module, val2_gen, parametrised by WIDTH.

Verification
REQ-031 SHALL cover: ADD with Val_Rn=0x7FFFFFFF and imm Val2=1 (Shift_operand=0x001) -> ALU_result=0x80000000, status=1001, out_valid one cycle later.
REQ-032 SHALL cover: SUB with Val_Rn=5 and Val_Rm=5, LSL #0 -> result 0, status=0110.
REQ-033 SHALL cover: imm with Shift_operand=0x4FF -> Val2=0xFF000000; MOV gives result 0xFF000000, N=1.
REQ-034 SHALL cover: MUL with Val_Rn=0x10000 and Val_Rm=0x10001 -> result 0x00010000 after 33 cycles, in_ready low for 32 cycles.
REQ-035 SHALL cover: flush asserted mid-MUL at cycle 10 -> out_valid never rises, in_ready=1 on the next cycle.
REQ-036 SHALL cover: out_ready held low with back-to-back ADDs -> the first result held, in_ready=0; releasing out_ready accepts the second with no bubble; PC=0x100 and imm24=0xFFFFFF gives Br_addr=0xFC.
